redmule_mem_arbiter: RTL and testbench

- Shares one downstream memory port (req/gnt/rvalid protocol) between the cluster core data port and the RedMulE narrow control/data port.
- Sits between the core and accelerator initiators and the TCDM/interconnect target.
- Arbitration: accelerator has fixed priority, with a starvation guard for the core.
- Tracks outstanding transactions in an owner FIFO so in-order responses are routed back to the correct initiator.

---
 rtl/redmule_pkg.sv | 13 +
 rtl/redmule_owner_fifo.sv | 74 +++++++
 rtl/redmule_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_redmule_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared types and default sizing for the RedMulE memory-port arbiter.
// The owner tag records which initiator each outstanding downstream transaction belongs to.
package redmule_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_ACC  = 1'b1
  } owner_e;

  localparam int unsigned MaxOutstandingDef = 4;
  localparam int unsigned StarveLimitDef    = 8;

endpackage

// File: rtl/redmule_owner_fifo.sv
// One-bit-wide FIFO of owner tags for in-flight downstream transactions.
// Push beyond full and pop from empty are ignored; count is registered.
module redmule_owner_fifo
  import redmule_pkg::*;
#(
  parameter int unsigned Depth = MaxOutstandingDef
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  owner_e                       data_i,
  input  logic                         pop_i,
  output owner_e                       data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CountWidth = $clog2(Depth + 1);

  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [Depth-1:0]      mem_q, mem_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CountWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = owner_e'(mem_q[rd_ptr_q]);

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/redmule_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between the core and the RedMulE narrow port.
// Accelerator has fixed priority; a starvation counter forces the core through after StarveLimit losses.
module redmule_mem_arbiter
  import redmule_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = MaxOutstandingDef,
  parameter int unsigned StarveLimit    = StarveLimitDef
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  core_req_i,
  input  logic                                  core_we_i,
  input  logic [DataWidth/8-1:0]                core_be_i,
  input  logic [AddrWidth-1:0]                  core_addr_i,
  input  logic [DataWidth-1:0]                  core_wdata_i,
  output logic                                  core_gnt_o,
  output logic                                  core_rvalid_o,
  output logic [DataWidth-1:0]                  core_rdata_o,
  input  logic                                  acc_req_i,
  input  logic                                  acc_we_i,
  input  logic [DataWidth/8-1:0]                acc_be_i,
  input  logic [AddrWidth-1:0]                  acc_addr_i,
  input  logic [DataWidth-1:0]                  acc_wdata_i,
  output logic                                  acc_gnt_o,
  output logic                                  acc_rvalid_o,
  output logic [DataWidth-1:0]                  acc_rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [DataWidth-1:0]                  mem_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  err_o
);

  localparam int unsigned StarveWidth = $clog2(StarveLimit + 1);
  localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(StarveLimit);

  owner_e                 winner, fifo_head, lock_owner_q, lock_owner_d;
  logic                   win_valid, handshake, resp_valid, forced_core;
  logic                   fifo_full, fifo_empty;
  logic                   lock_valid_q, lock_valid_d;
  logic                   err_q, err_d;
  logic [StarveWidth-1:0] starve_cnt_q, starve_cnt_d;

  assign forced_core = (starve_cnt_q == StarveMax) & core_req_i;

  // A pending ungranted request keeps its owner so the downstream request stays stable.
  always_comb begin
    winner    = OWNER_CORE;
    win_valid = 1'b0;
    if (!fifo_full) begin
      if (lock_valid_q) begin
        winner    = lock_owner_q;
        win_valid = (lock_owner_q == OWNER_ACC) ? acc_req_i : core_req_i;
      end else if (acc_req_i && !forced_core) begin
        winner    = OWNER_ACC;
        win_valid = 1'b1;
      end else if (core_req_i) begin
        winner    = OWNER_CORE;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o   = win_valid;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (win_valid) begin
      if (winner == OWNER_ACC) begin
        mem_we_o    = acc_we_i;
        mem_be_o    = acc_be_i;
        mem_addr_o  = acc_addr_i;
        mem_wdata_o = acc_wdata_i;
      end else begin
        mem_we_o    = core_we_i;
        mem_be_o    = core_be_i;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
      end
    end
  end

  assign handshake  = win_valid & mem_gnt_i;
  assign acc_gnt_o  = handshake & (winner == OWNER_ACC);
  assign core_gnt_o = handshake & (winner == OWNER_CORE);

  // Responses arriving with nothing outstanding are dropped and flagged instead of routed.
  assign resp_valid    = mem_rvalid_i & ~fifo_empty;
  assign acc_rvalid_o  = resp_valid & (fifo_head == OWNER_ACC);
  assign core_rvalid_o = resp_valid & (fifo_head == OWNER_CORE);
  assign acc_rdata_o   = acc_rvalid_o ? mem_rdata_i : '0;
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign err_o         = err_q;

  always_comb begin
    lock_valid_d = win_valid & ~mem_gnt_i;
    lock_owner_d = winner;
    err_d        = err_q | (mem_rvalid_i & fifo_empty);
    starve_cnt_d = starve_cnt_q;
    if (!core_req_i || core_gnt_o) begin
      starve_cnt_d = '0;
    end else if (win_valid && (winner == OWNER_ACC) && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + StarveWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWNER_CORE;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  redmule_owner_fifo #(
    .Depth(MaxOutstanding)
  ) i_owner_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (handshake),
    .data_i (winner),
    .pop_i  (mem_rvalid_i),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(outstanding_o)
  );

endmodule

// File: tb/tb_redmule_mem_arbiter.sv
// Randomized and directed bench for redmule_mem_arbiter with a queue-based reference model
// and a response scoreboard drained by an independent monitor.
module tb_redmule_mem_arbiter;
  import redmule_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAX_OUT = 4;
  localparam int STARVE = 8;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic          core_req_i, core_we_i, acc_req_i, acc_we_i;
  logic [BW-1:0] core_be_i, acc_be_i;
  logic [AW-1:0] core_addr_i, acc_addr_i;
  logic [DW-1:0] core_wdata_i, acc_wdata_i;
  logic          core_gnt_o, core_rvalid_o, acc_gnt_o, acc_rvalid_o;
  logic [DW-1:0] core_rdata_o, acc_rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [2:0]    outstanding_o;
  logic          err_o;

  redmule_mem_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAX_OUT), .StarveLimit(STARVE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .acc_req_i(acc_req_i), .acc_we_i(acc_we_i), .acc_be_i(acc_be_i),
    .acc_addr_i(acc_addr_i), .acc_wdata_i(acc_wdata_i),
    .acc_gnt_o(acc_gnt_o), .acc_rvalid_o(acc_rvalid_o), .acc_rdata_o(acc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding owners (1 = acc) and bookkeeping derived from the arbitration rules.
  typedef struct {
    bit          owner;
    logic [31:0] data;
  } resp_t;

  bit    mdl_q[$];
  resp_t exp_q[$];
  int    starve;
  bit    lock_v, lock_own, err_m;
  bit    m_core_gnt, m_acc_gnt;

  logic          s_core_gnt, s_acc_gnt, s_mem_req, s_core_rv, s_acc_rv, s_err;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_core_rdata, s_acc_rdata;
  logic [2:0]    s_out;

  // Response scoreboard: every routed response must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_ni && (core_rvalid_o || acc_rvalid_o)) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {core_rvalid_o, acc_rvalid_o}, 2'b00);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_owner", {acc_rvalid_o, core_rvalid_o}, e.owner ? 2'b10 : 2'b01);
        check("resp_data", e.owner ? acc_rdata_o : core_rdata_o, e.data);
      end
    end
  end

  // One clock cycle: inputs are already driven; check at negedge, advance the model at posedge.
  task automatic step();
    bit full, forced, has_win, win, e_rv, hs;
    full    = mdl_q.size() >= MAX_OUT;
    forced  = (starve == STARVE) && core_req_i;
    has_win = 1'b0;
    win     = 1'b0;
    if (!full) begin
      if (lock_v) begin
        win     = lock_own;
        has_win = lock_own ? acc_req_i : core_req_i;
      end else if (acc_req_i && !forced) begin
        win = 1'b1; has_win = 1'b1;
      end else if (core_req_i) begin
        win = 1'b0; has_win = 1'b1;
      end
    end
    m_acc_gnt  = has_win && win && mem_gnt_i;
    m_core_gnt = has_win && !win && mem_gnt_i;
    e_rv       = mem_rvalid_i && (mdl_q.size() > 0);
    if (e_rv) exp_q.push_back('{owner: mdl_q[0], data: mem_rdata_i});

    @(negedge clk);
    check("mem_req", mem_req_o, has_win);
    check("core_gnt", core_gnt_o, m_core_gnt);
    check("acc_gnt", acc_gnt_o, m_acc_gnt);
    if (has_win) begin
      check("mem_addr", mem_addr_o, win ? acc_addr_i : core_addr_i);
      check("mem_we", mem_we_o, win ? acc_we_i : core_we_i);
      check("mem_be", mem_be_o, win ? acc_be_i : core_be_i);
      check("mem_wdata", mem_wdata_o, win ? acc_wdata_i : core_wdata_i);
    end
    check("rvalid_present", core_rvalid_o | acc_rvalid_o, e_rv);
    if (!(e_rv && !mdl_q[0])) check("core_rdata_idle", core_rdata_o, 0);
    if (!(e_rv && mdl_q[0])) check("acc_rdata_idle", acc_rdata_o, 0);
    check("outstanding", outstanding_o, mdl_q.size());
    check("err", err_o, err_m);
    s_core_gnt = core_gnt_o;  s_acc_gnt = acc_gnt_o;  s_mem_req = mem_req_o;
    s_mem_addr = mem_addr_o;  s_core_rv = core_rvalid_o;  s_acc_rv = acc_rvalid_o;
    s_core_rdata = core_rdata_o;  s_acc_rdata = acc_rdata_o;
    s_out = outstanding_o;  s_err = err_o;

    @(posedge clk);
    hs = has_win && mem_gnt_i;
    if (e_rv) void'(mdl_q.pop_front());
    else if (mem_rvalid_i) err_m = 1'b1;
    if (hs) mdl_q.push_back(win);
    if (!core_req_i || m_core_gnt) starve = 0;
    else if (has_win && win) starve = (starve + 1 > STARVE) ? STARVE : starve + 1;
    lock_v   = has_win && !mem_gnt_i;
    lock_own = win;
    #1;
  endtask

  task automatic do_reset();
    core_req_i = 0; core_we_i = 0; core_be_i = '0; core_addr_i = '0; core_wdata_i = '0;
    acc_req_i = 0;  acc_we_i = 0;  acc_be_i = '0;  acc_addr_i = '0;  acc_wdata_i = '0;
    mem_gnt_i = 0;  mem_rvalid_i = 0; mem_rdata_i = '0;
    rst_ni = 1'b0;
    mdl_q.delete(); exp_q.delete();
    starve = 0; lock_v = 0; lock_own = 0; err_m = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    check("rst_ctrl", {mem_req_o, mem_we_o, core_gnt_o, acc_gnt_o, core_rvalid_o, acc_rvalid_o, err_o}, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_fields", {mem_be_o, mem_addr_o, mem_wdata_o}, 0);
    check("rst_rdata", {core_rdata_o, acc_rdata_o}, 0);
  endtask

  task automatic drain();
    core_req_i = 0; acc_req_i = 0; mem_gnt_i = 0;
    for (int i = 0; i < 2 * MAX_OUT && mdl_q.size() > 0; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
      step();
    end
    mem_rvalid_i = 1'b0;
    step();
    check("drained", s_out, 0);
  endtask

  initial begin
    // Single core read, response two cycles after the grant.
    do_reset();
    step();
    core_req_i = 1; core_we_i = 0; core_be_i = 4'hF; core_addr_i = 32'h100; mem_gnt_i = 1;
    step();
    check("t1_core_gnt", s_core_gnt, 1);
    check("t1_addr", s_mem_addr, 32'h100);
    core_req_i = 0; mem_gnt_i = 0;
    step();
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    step();
    check("t1_core_rvalid", s_core_rv, 1);
    check("t1_core_rdata", s_core_rdata, 32'hDEADBEEF);
    check("t1_acc_rvalid", s_acc_rv, 0);
    mem_rvalid_i = 0;

    // Continuous contention: acc wins 8 cycles, core forced on the 9th, repeating.
    do_reset();
    core_req_i = 1; core_addr_i = 32'hC000_0000; acc_req_i = 1; acc_addr_i = 32'hA000_0000;
    mem_gnt_i = 1;
    for (int k = 1; k <= 27; k++) begin
      mem_rvalid_i = (mdl_q.size() > 0); mem_rdata_i = k;
      step();
      check("t2_core_gnt", s_core_gnt, (k % 9) == 0);
      check("t2_acc_gnt", s_acc_gnt, (k % 9) != 0);
    end
    drain();

    // Lock: acc stalled by the target, core arrives; request must not switch.
    do_reset();
    acc_req_i = 1; acc_addr_i = 32'hA000_0040; mem_gnt_i = 0;
    core_addr_i = 32'hC000_0080;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) core_req_i = 1;
      if (k == 4) mem_gnt_i = 1;
      step();
      check("t3_addr", s_mem_addr, 32'hA000_0040);
      check("t3_core_gnt", s_core_gnt, 0);
      check("t3_acc_gnt", s_acc_gnt, k == 4);
    end
    acc_req_i = 0;
    step();
    check("t3_core_after", s_core_gnt, 1);
    drain();

    // FIFO full: core blocked until the cycle after the first response.
    do_reset();
    acc_req_i = 1; mem_gnt_i = 1;
    for (int k = 0; k < MAX_OUT; k++) begin
      acc_addr_i = 32'h200 + 4 * k;
      step();
      check("t4_acc_gnt", s_acc_gnt, 1);
    end
    acc_req_i = 0; core_req_i = 1; core_addr_i = 32'h300;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid_i = (k == 2); mem_rdata_i = 32'h1234;
      step();
      check("t4_full_out", s_out, MAX_OUT);
      check("t4_full_gnt", s_core_gnt, 0);
      check("t4_full_req", s_mem_req, 0);
    end
    mem_rvalid_i = 0;
    step();
    check("t4_core_gnt", s_core_gnt, 1);
    drain();

    // In-order routing: acc, core, acc then data 1, 2, 3.
    do_reset();
    mem_gnt_i = 1;
    acc_req_i = 1; step();
    acc_req_i = 0; core_req_i = 1; step();
    core_req_i = 0; acc_req_i = 1; step();
    acc_req_i = 0; mem_gnt_i = 0;
    for (int d = 1; d <= 3; d++) begin
      mem_rvalid_i = 1; mem_rdata_i = d;
      step();
      check("t5_core_rv", s_core_rv, d == 2);
      check("t5_acc_rv", s_acc_rv, d != 2);
      check("t5_data", (d == 2) ? s_core_rdata : s_acc_rdata, d);
    end
    mem_rvalid_i = 0;
    step();

    // Spurious response with nothing outstanding: dropped, sticky error.
    do_reset();
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    step();
    check("t6_no_rv", {s_core_rv, s_acc_rv}, 0);
    check("t6_err_same", s_err, 0);
    mem_rvalid_i = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_err_sticky", s_err, 1);
      check("t6_out", s_out, 0);
    end
    do_reset();

    // Randomized traffic, ending in a reset with transactions still in flight.
    for (int c = 0; c < 3000; c++) begin
      if (!core_req_i && $urandom_range(0, 2) == 0) begin
        core_req_i = 1; core_we_i = $urandom; core_be_i = $urandom;
        core_addr_i = $urandom; core_wdata_i = $urandom;
      end
      if (!acc_req_i && $urandom_range(0, 3) != 0) begin
        acc_req_i = 1; acc_we_i = $urandom; acc_be_i = $urandom;
        acc_addr_i = $urandom; acc_wdata_i = $urandom;
      end
      mem_gnt_i    = $urandom_range(0, 3) != 0;
      mem_rvalid_i = (mdl_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = $urandom;
      step();
      if (m_core_gnt) core_req_i = 0;
      if (m_acc_gnt) acc_req_i = 0;
    end
    check("rand_scoreboard_empty", exp_q.size(), 0);
    do_reset();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
